tia_horizontal_motion: RTL and testbench

Horizontal-motion (HMOVE) sequencer for the TIA, directly downstream of the write-address decoder. It holds the five 4-bit motion registers (P0, P1, M0, M1, BL), loaded from data bus bits D7..D4 on the decoder's `p0hm`..`blhm` strobes and cleared by `hmclr`. On an `hmove` strobe it runs a 64-clock sequence that emits a per-object count of extra-clock pulses to the object position counters.

---
 rtl/tia_horizontal_motion_pkg.sv | 22 ++
 rtl/tia_horizontal_motion_if.sv | 30 +++
 rtl/tia_horizontal_motion_object.sv | 44 ++++
 rtl/tia_horizontal_motion.sv | 98 +++++++++
 tb/tb_tia_horizontal_motion.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/tia_horizontal_motion_pkg.sv
// Shared TIA definitions: object indices and HMOVE sequencing constants.
package tia_pkg;

    typedef enum logic [2:0] {
        OBJ_P0 = 3'd0,
        OBJ_P1 = 3'd1,
        OBJ_M0 = 3'd2,
        OBJ_M1 = 3'd3,
        OBJ_BL = 3'd4
    } tia_obj_e;

    localparam int unsigned TIA_HM_NOBJ  = 5;
    localparam int unsigned TIA_HM_STEPS = 16;
    localparam int unsigned TIA_HM_PHASE = 4;
    localparam logic [3:0]  TIA_HM_BIAS  = 4'b1000;

    // Signed motion value -8..+7 maps to an unsigned extra-pulse count 0..15.
    function automatic logic [3:0] hm_target(input logic [3:0] hm);
        return hm ^ TIA_HM_BIAS;
    endfunction

endpackage

// File: rtl/tia_horizontal_motion_if.sv
// Decoder <-> HMOVE sequencer bus. hm_rd exists only with TIA_HM_READBACK_EN.
interface tia_horizontal_motion_if;

    logic [3:0]  d;
    logic        p0hm, p1hm, m0hm, m1hm, blhm;
    logic        hmove;
    logic        hmclr;
    logic        p0ec, p1ec, m0ec, m1ec, blec;
    logic        busy;
`ifdef TIA_HM_READBACK_EN
    logic [19:0] hm_rd;
`endif

    modport master (
        output d, p0hm, p1hm, m0hm, m1hm, blhm, hmove, hmclr,
        input  p0ec, p1ec, m0ec, m1ec, blec, busy
`ifdef TIA_HM_READBACK_EN
        , input hm_rd
`endif
    );

    modport slave (
        input  d, p0hm, p1hm, m0hm, m1hm, blhm, hmove, hmclr,
        output p0ec, p1ec, m0ec, m1ec, blec, busy
`ifdef TIA_HM_READBACK_EN
        , output hm_rd
`endif
    );

endinterface

// File: rtl/tia_horizontal_motion_object.sv
// One movable object: 4-bit motion register, move latch, step compare and
// extra-clock pulse. hm_o is present only with TIA_HM_READBACK_EN.
module tia_hm_object
    import tia_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic       clr_i,
    input  logic [3:0] d_i,
    input  logic       start_i,
    input  logic       step_i,
    input  logic [3:0] k_i,
    output logic       ec_o
`ifdef TIA_HM_READBACK_EN
    , output logic [3:0] hm_o
`endif
);

    logic [3:0] hm_q;
    logic       latch_q;
    logic       hit;

    assign hit  = (k_i == hm_target(hm_q));
    assign ec_o = step_i & latch_q & ~hit;
`ifdef TIA_HM_READBACK_EN
    assign hm_o = hm_q;
`endif

    // Motion register: clear has priority over a write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        hm_q <= '0;
        else if (clr_i) hm_q <= '0;
        else if (wr_i)  hm_q <= d_i;
    end

    // Move latch: set on sequence start, dropped when the step count reaches target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          latch_q <= 1'b0;
        else if (start_i)                 latch_q <= 1'b1;
        else if (step_i && latch_q && hit) latch_q <= 1'b0;
    end

endmodule

// File: rtl/tia_horizontal_motion.sv
// HMOVE sequencer: strobe edge detectors, IDLE/RUN FSM, phase and step
// counters, five tia_hm_object instances. Optional macro TIA_HM_READBACK_EN
// adds the hm_rd debug readback of all motion registers.
module tia_horizontal_motion
    import tia_pkg::*;
(
    input logic                     clk,
    input logic                     rst,
    tia_horizontal_motion_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0] state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [3:0] k_q, k_d;
    logic [6:0] strb, strb_q, rise;   // {hmclr, hmove, bl, m1, m0, p1, p0}
    logic [4:0] wr;
    logic       clr, start, step;
    logic [4:0] ec;

    assign strb  = {bus.hmclr, bus.hmove, bus.blhm, bus.m1hm, bus.m0hm, bus.p1hm, bus.p0hm};
    assign rise  = strb & ~strb_q;
    assign wr    = rise[4:0];
    assign clr   = rise[6];
    assign start = rise[5];
    assign step  = (state_q == ST_RUN) && (phase_q == 2'(TIA_HM_PHASE - 1));

    // Registered strobe copies so a multi-cycle strobe acts only once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) strb_q <= '0;
        else     strb_q <= strb;
    end

    // Next state: an hmove rise (re)starts; otherwise RUN advances phase, and k on phase 3.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        k_d     = k_q;
        if (start) begin
            state_d = ST_RUN;
            phase_d = '0;
            k_d     = '0;
        end else if (state_q == ST_RUN) begin
            phase_d = phase_q + 2'd1;
            if (step) begin
                k_d = k_q + 4'd1;
                if (k_q == 4'(TIA_HM_STEPS - 1)) state_d = ST_IDLE;
            end
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            k_q     <= k_d;
        end
    end

`ifdef TIA_HM_READBACK_EN
    logic [3:0] hm_obj [TIA_HM_NOBJ];
`endif

    for (genvar i = 0; i < TIA_HM_NOBJ; i++) begin : g_obj
        tia_hm_object u_obj (
            .clk     (clk),
            .rst     (rst),
            .wr_i    (wr[i]),
            .clr_i   (clr),
            .d_i     (bus.d),
            .start_i (start),
            .step_i  (step),
            .k_i     (k_q),
            .ec_o    (ec[i])
`ifdef TIA_HM_READBACK_EN
            , .hm_o  (hm_obj[i])
`endif
        );
    end

    assign bus.p0ec = ec[OBJ_P0];
    assign bus.p1ec = ec[OBJ_P1];
    assign bus.m0ec = ec[OBJ_M0];
    assign bus.m1ec = ec[OBJ_M1];
    assign bus.blec = ec[OBJ_BL];
    assign bus.busy = (state_q == ST_RUN);
`ifdef TIA_HM_READBACK_EN
    assign bus.hm_rd = {hm_obj[OBJ_BL], hm_obj[OBJ_M1], hm_obj[OBJ_M0], hm_obj[OBJ_P1], hm_obj[OBJ_P0]};
`endif

endmodule

// File: tb/tb_tia_horizontal_motion.sv
// Directed bench for tia_horizontal_motion: table of motion values with
// hand-computed pulse counts, plus held-strobe, clear-vs-write, mid-run write,
// restart and reset sequences. Readback checks need TIA_HM_READBACK_EN.
module tb_tia_horizontal_motion;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tia_horizontal_motion_if bus ();

    tia_horizontal_motion dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] hm  [5];
        int         exp [5];
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cnt [5];
    int         busy_n;
    int         misplaced;
    int         tgt [5];
    vec_t       vecs [6];
    string      nm [5] = '{"p0", "p1", "m0", "m1", "bl"};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ec_vec();
        return {bus.blec, bus.m1ec, bus.m0ec, bus.p1ec, bus.p0ec};
    endfunction

    task automatic set_strobe(input int i, input logic v);
        case (i)
            0: bus.p0hm = v;
            1: bus.p1hm = v;
            2: bus.m0hm = v;
            3: bus.m1hm = v;
            default: bus.blhm = v;
        endcase
    endtask

    task automatic write_hm(input int i, input logic [3:0] v);
        @(negedge clk);
        bus.d = v;
        set_strobe(i, 1'b1);
        @(negedge clk);
        set_strobe(i, 1'b0);
    endtask

    task automatic write_all(input logic [3:0] v);
        for (int i = 0; i < 5; i++) write_hm(i, v);
    endtask

    // ev_kind: 0 none, 1 write P0 = ev_val at cycle ev_at, 2 hmove restart at ev_at.
    // Cycle n is the cycle after edge T+n, T being the edge that samples hmove.
    task automatic run_seq(input int ncyc, input int ev_at, input int ev_kind, input logic [3:0] ev_val);
        logic [4:0] e;
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        busy_n    = 0;
        misplaced = 0;
        @(negedge clk);
        bus.hmove = 1'b1;
        @(negedge clk);
        bus.hmove = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            e = ec_vec();
            if (bus.busy) busy_n++;
            for (int i = 0; i < 5; i++) begin
                if (e[i]) begin
                    cnt[i]++;
                    if ((n % 4) != 3 || (n / 4) >= tgt[i]) misplaced++;
                end
            end
            if (n == ev_at && ev_kind == 1) begin
                bus.d    = ev_val;
                bus.p0hm = 1'b1;
            end
            if (n == ev_at && ev_kind == 2) bus.hmove = 1'b1;
            if (n == ev_at + 1) begin
                bus.p0hm  = 1'b0;
                bus.hmove = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int post;

        vecs[0] = '{hm: '{4'h7, 4'h8, 4'h0, 4'hF, 4'h1}, exp: '{15, 0, 8, 7, 9}};
        vecs[1] = '{hm: '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8}, exp: '{0, 0, 0, 0, 0}};
        vecs[2] = '{hm: '{4'h7, 4'h7, 4'h7, 4'h7, 4'h7}, exp: '{15, 15, 15, 15, 15}};
        vecs[3] = '{hm: '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4}, exp: '{8, 9, 10, 11, 12}};
        vecs[4] = '{hm: '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD}, exp: '{1, 2, 3, 4, 5}};
        vecs[5] = '{hm: '{4'hE, 4'hF, 4'h5, 4'h6, 4'h8}, exp: '{6, 7, 13, 14, 0}};

        bus.d = '0;
        bus.p0hm = 0; bus.p1hm = 0; bus.m0hm = 0; bus.m1hm = 0; bus.blhm = 0;
        bus.hmove = 0;
        bus.hmclr = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ec", int'(ec_vec()), 0);
        check("reset_busy", int'(bus.busy), 0);
`ifdef TIA_HM_READBACK_EN
        check("reset_hm_rd", int'(bus.hm_rd), 0);
`endif
        rst = 1'b0;

        write_hm(0, 4'h7);
`ifdef TIA_HM_READBACK_EN
        check("rd_p0_after_write", int'(bus.hm_rd[3:0]), 7);
`endif

        // Table of static motion values.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 5; i++) begin
                write_hm(i, vecs[v].hm[i]);
                tgt[i] = vecs[v].exp[i];
            end
`ifdef TIA_HM_READBACK_EN
            check($sformatf("v%0d_rd", v), int'(bus.hm_rd),
                  int'({vecs[v].hm[4], vecs[v].hm[3], vecs[v].hm[2], vecs[v].hm[1], vecs[v].hm[0]}));
`endif
            run_seq(70, -1, 0, 4'h0);
            for (int i = 0; i < 5; i++)
                check($sformatf("v%0d_%s_pulses", v, nm[i]), cnt[i], vecs[v].exp[i]);
            check($sformatf("v%0d_pulse_timing", v), misplaced, 0);
            check($sformatf("v%0d_busy_cycles", v), busy_n, 64);
        end

        // p0hm held three cycles: only the first-cycle data (0x3 -> 11 pulses) is taken.
        write_all(4'h8);
        @(negedge clk);
        bus.d = 4'h3; bus.p0hm = 1'b1;
        @(negedge clk);
        bus.d = 4'hA;
        @(negedge clk);
        bus.d = 4'h5;
        @(negedge clk);
        bus.p0hm = 1'b0;
        tgt = '{11, 0, 0, 0, 0};
        run_seq(70, -1, 0, 4'h0);
        check("held_strobe_p0_pulses", cnt[0], 11);
        check("held_strobe_timing", misplaced, 0);

        // hmclr and m0hm rising together: clear wins, every object gets 8.
        write_all(4'h7);
        @(negedge clk);
        bus.d = 4'h5; bus.hmclr = 1'b1; bus.m0hm = 1'b1;
        @(negedge clk);
        bus.hmclr = 1'b0; bus.m0hm = 1'b0;
        tgt = '{8, 8, 8, 8, 8};
        run_seq(70, -1, 0, 4'h0);
        for (int i = 0; i < 5; i++)
            check($sformatf("clr_%s_pulses", nm[i]), cnt[i], 8);
        check("clr_busy_cycles", busy_n, 64);

        // P0 target 8, rewritten to 0x8 while k = 5: the latch is never
        // cleared by compare, so P0 pulses at every k = 0..15.
        write_hm(0, 4'h0);
        run_seq(70, 20, 1, 4'h8);
        check("midrun_p0_pulses", cnt[0], 16);
        check("midrun_p1_pulses", cnt[1], 8);
        check("midrun_busy_cycles", busy_n, 64);

        // hmove again at cycle 30: 7 pulses kept, then a full 15 after restart.
        write_all(4'h7);
        run_seq(110, 30, 2, 4'h0);
        for (int i = 0; i < 5; i++)
            check($sformatf("restart_%s_pulses", nm[i]), cnt[i], 22);
        check("restart_busy_cycles", busy_n, 95);

        // Reset asserted in the k = 5 pulse cycle of a run.
        @(negedge clk);
        bus.hmove = 1'b1;
        @(negedge clk);
        bus.hmove = 1'b0;
        repeat (23) @(negedge clk);
        check("prerst_ec", int'(ec_vec()), 5'h1F);
        rst = 1'b1;
        #1;
        check("rst_ec_drop", int'(ec_vec()), 0);
        check("rst_busy_drop", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        post = 0;
        for (int n = 0; n < 12; n++) begin
            if (ec_vec() != 5'b0 || bus.busy) post++;
            @(negedge clk);
        end
        check("post_rst_quiet", post, 0);
`ifdef TIA_HM_READBACK_EN
        check("post_rst_hm_rd", int'(bus.hm_rd), 0);
`endif
        tgt = '{8, 8, 8, 8, 8};
        run_seq(70, -1, 0, 4'h0);
        for (int i = 0; i < 5; i++)
            check($sformatf("after_rst_%s_pulses", nm[i]), cnt[i], 8);
        check("after_rst_timing", misplaced, 0);
        check("after_rst_busy_cycles", busy_n, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
